// File: rtl/cpu_pkg.sv
// Shared CPU types: datapath widths, WB result-select encoding and
// the decoded control bundle latched into the EX->WB register.
package cpu_pkg;

  localparam int WIDTH = 32;
  localparam int RADDR = 5;

  // Register-file write-data source in WB.
  typedef enum logic [1:0] {
    RS_LO   = 2'b00,
    RS_GPIO = 2'b01,
    RS_MFLO = 2'b10,
    RS_MFHI = 2'b11
  } regsel_t;

  typedef struct packed {
    logic             regwrite;
    regsel_t          regsel;
    logic             enhilo;
    logic             gpio_we;
    logic [RADDR-1:0] waddr;
  } wb_ctrl_t;

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser with async active-high reset.
// Ports: clk, rst, i_d (async input), o_q (synchronised, 2-cycle latency).
module sync2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/writeback_stage.sv
// EX->WB pipeline register plus commit: register-file write port,
// architectural HI/LO, GPIO output register and gpio_in synchroniser.
// Inputs : clk, rst, ex_* (decoded EX slot), gpio_in, stall, flush.
// Outputs: wb_we/wb_waddr/wb_wdata (regfile port), wb_valid,
//          hi_q, lo_q, gpio_out.
module writeback_stage #(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int RADDR = cpu_pkg::RADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_regwrite,
  input  logic [1:0]       ex_regsel,
  input  logic             ex_enhilo,
  input  logic             ex_gpio_we,
  input  logic [RADDR-1:0] ex_waddr,
  input  logic [WIDTH-1:0] ex_alu_lo,
  input  logic [WIDTH-1:0] ex_alu_hi,
  input  logic [WIDTH-1:0] ex_rt_data,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic             stall,
  input  logic             flush,
  output logic             wb_we,
  output logic [RADDR-1:0] wb_waddr,
  output logic [WIDTH-1:0] wb_wdata,
  output logic             wb_valid,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic [WIDTH-1:0] gpio_out
);

  import cpu_pkg::*;

  wb_ctrl_t         w_ex_ctrl;
  wb_ctrl_t         r_ctrl;
  logic             r_valid;
  logic [WIDTH-1:0] r_alu_lo;
  logic [WIDTH-1:0] r_alu_hi;
  logic [WIDTH-1:0] r_rt_data;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_gpio_out;

  logic [WIDTH-1:0] w_gpio_sync;
  logic             w_commit;
  logic [WIDTH-1:0] w_wdata;

  sync2 #(
    .W (WIDTH)
  ) u_gpio_sync (
    .clk (clk),
    .rst (rst),
    .i_d (gpio_in),
    .o_q (w_gpio_sync)
  );

  always_comb begin
    w_ex_ctrl          = '0;
    w_ex_ctrl.regwrite = ex_regwrite;
    w_ex_ctrl.regsel   = regsel_t'(ex_regsel);
    w_ex_ctrl.enhilo   = ex_enhilo;
    w_ex_ctrl.gpio_we  = ex_gpio_we;
    w_ex_ctrl.waddr    = ex_waddr;
  end

  // Flush beats stall: a flushed slot must never commit later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_alu_lo  <= '0;
      r_alu_hi  <= '0;
      r_rt_data <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_valid   <= ex_valid;
      r_ctrl    <= w_ex_ctrl;
      r_alu_lo  <= ex_alu_lo;
      r_alu_hi  <= ex_alu_hi;
      r_rt_data <= ex_rt_data;
    end
  end

  assign w_commit = r_valid & ~stall;

  // HI/LO and GPIO change at the edge closing the commit cycle, so a
  // following mfhi/mflo in WB already sees the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_gpio_out <= '0;
    end else begin
      if (w_commit && r_ctrl.enhilo) begin
        r_hi <= r_alu_hi;
        r_lo <= r_alu_lo;
      end
      if (w_commit && r_ctrl.gpio_we) begin
        r_gpio_out <= r_rt_data;
      end
    end
  end

  always_comb begin
    w_wdata = r_alu_lo;
    unique case (r_ctrl.regsel)
      RS_LO:   w_wdata = r_alu_lo;
      RS_GPIO: w_wdata = w_gpio_sync;
      RS_MFLO: w_wdata = r_lo;
      RS_MFHI: w_wdata = r_hi;
      default: w_wdata = r_alu_lo;
    endcase
  end

  // $0 is hardwired zero; never present a write to it.
  assign wb_we    = w_commit & r_ctrl.regwrite & (r_ctrl.waddr != '0);
  assign wb_waddr = r_ctrl.waddr;
  assign wb_wdata = w_wdata;
  assign wb_valid = r_valid;
  assign hi_q     = r_hi;
  assign lo_q     = r_lo;
  assign gpio_out = r_gpio_out;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed EX slots push expected
// regfile writes; a negedge monitor pops and compares every wb_we pulse.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_regwrite = 1'b0;
  logic [1:0]  ex_regsel = 2'b00;
  logic        ex_enhilo = 1'b0;
  logic        ex_gpio_we = 1'b0;
  logic [4:0]  ex_waddr = '0;
  logic [31:0] ex_alu_lo = '0;
  logic [31:0] ex_alu_hi = '0;
  logic [31:0] ex_rt_data = '0;
  logic [31:0] gpio_in = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_valid;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] gpio_out;

  int n_pass = 0;
  int n_total = 0;
  logic [36:0] exp_q[$];

  writeback_stage dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_regwrite (ex_regwrite),
    .ex_regsel   (ex_regsel),
    .ex_enhilo   (ex_enhilo),
    .ex_gpio_we  (ex_gpio_we),
    .ex_waddr    (ex_waddr),
    .ex_alu_lo   (ex_alu_lo),
    .ex_alu_hi   (ex_alu_hi),
    .ex_rt_data  (ex_rt_data),
    .gpio_in     (gpio_in),
    .stall       (stall),
    .flush       (flush),
    .wb_we       (wb_we),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .wb_valid    (wb_valid),
    .hi_q        (hi_q),
    .lo_q        (lo_q),
    .gpio_out    (gpio_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && wb_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, wb_waddr, wb_wdata}, 64'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wb_write", {27'd0, wb_waddr, wb_wdata}, {27'd0, e});
      end
    end
  end

  task automatic drive(input logic v, input logic rw,
                       input logic [1:0] rs, input logic eh,
                       input logic gw, input logic [4:0] wa,
                       input logic [31:0] lo, input logic [31:0] hi,
                       input logic [31:0] rt);
    ex_valid    = v;
    ex_regwrite = rw;
    ex_regsel   = rs;
    ex_enhilo   = eh;
    ex_gpio_we  = gw;
    ex_waddr    = wa;
    ex_alu_lo   = lo;
    ex_alu_hi   = hi;
    ex_rt_data  = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ex();
    ex_valid    = 1'b0;
    ex_regwrite = 1'b0;
    ex_regsel   = 2'b00;
    ex_enhilo   = 1'b0;
    ex_gpio_we  = 1'b0;
    ex_waddr    = '0;
    ex_alu_lo   = '0;
    ex_alu_hi   = '0;
    ex_rt_data  = '0;
  endtask

  task automatic bubble();
    drive(0, 0, 2'b00, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_valid", wb_valid, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_hi", hi_q, 0);
    chk("rst_lo", lo_q, 0);
    chk("rst_gpio", gpio_out, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bubble();

    // 1: addu $5 = 7
    exp_q.push_back({5'd5, 32'h0000_0007});
    drive(1, 1, 2'b00, 0, 0, 5'd5, 32'h7, 32'h0, 32'h0);
    chk("addu_valid", wb_valid, 1);
    bubble();

    // 2: mul {1,2}, mfhi $3, mflo $4
    exp_q.push_back({5'd3, 32'h1});
    exp_q.push_back({5'd4, 32'h2});
    drive(1, 0, 2'b00, 1, 0, 5'd7, 32'h2, 32'h1, 32'h0);
    chk("mul_we", wb_we, 0);
    chk("mul_hi_old", hi_q, 0);
    drive(1, 1, 2'b11, 0, 0, 5'd3, 32'hDEAD, 32'h0, 32'h0);
    chk("hi_new", hi_q, 32'h1);
    chk("lo_new", lo_q, 32'h2);
    drive(1, 1, 2'b10, 0, 0, 5'd4, 32'hBEEF, 32'h0, 32'h0);
    bubble();

    // 3: write to $0 suppressed
    drive(1, 1, 2'b00, 0, 0, 5'd0, 32'hFFFF, 32'h0, 32'h0);
    chk("r0_we", wb_we, 0);
    chk("r0_valid", wb_valid, 1);
    bubble();

    // 4: GPIO out, then synchronised GPIO in
    drive(1, 0, 2'b00, 0, 1, 5'd2, 32'h0, 32'h0, 32'hA5A5_A5A5);
    chk("gpio_pre", gpio_out, 0);
    gpio_in = 32'h55;
    bubble();
    chk("gpio_out", gpio_out, 32'hA5A5_A5A5);
    bubble();
    bubble();
    exp_q.push_back({5'd6, 32'h55});
    drive(1, 1, 2'b01, 0, 0, 5'd6, 32'h0, 32'h0, 32'h0);
    bubble();

    // 5: addi held 3 cycles by stall, then one write
    exp_q.push_back({5'd9, 32'h1234});
    drive(1, 1, 2'b00, 0, 0, 5'd9, 32'h1234, 32'h0, 32'h0);
    clr_ex();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_we", wb_we, 0);
      chk("stall_hold", wb_valid, 1);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    #1;
    chk("unstall_we", wb_we, 1);
    @(posedge clk);
    #1;
    chk("after_commit", wb_valid, 0);

    // flush + stall together
    drive(1, 1, 2'b00, 0, 0, 5'd10, 32'h10, 32'h0, 32'h0);
    clr_ex();
    stall = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_stall", wb_valid, 0);
    stall = 1'b0;
    flush = 1'b0;
    // flush alone turns incoming slot into a bubble
    flush = 1'b1;
    drive(1, 1, 2'b00, 0, 0, 5'd11, 32'h11, 32'h0, 32'h0);
    flush = 1'b0;
    chk("flush_only", wb_valid, 0);
    bubble();
    bubble();

    // 6: async reset during mul commit cycle
    drive(1, 0, 2'b00, 1, 0, 5'd0, 32'hBEEF, 32'hDEAD, 32'h0);
    chk("mul2_valid", wb_valid, 1);
    clr_ex();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hi", hi_q, 0);
    chk("arst_lo", lo_q, 0);
    chk("arst_gpio", gpio_out, 0);
    chk("arst_we", wb_we, 0);
    chk("arst_valid", wb_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bubble();
    bubble();
    chk("post_rst_hi", hi_q, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
